// File: rtl/subckt_bist_pkg.sv
// Shared types and default constants for the subcircuit BIST sequencer.
package subckt_bist_pkg;
  typedef enum logic [2:0] {IDLE, DUT_RST, RUN, FLUSH, DONE} state_t;

  localparam int          DUT_RST_CYCLES = 2;
  localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS_DEF  = 16'hB400;
  localparam logic [15:0] MISR_TAPS_DEF  = 16'h1021;
endpackage

// File: rtl/bist_misr.sv
// Serial-input MISR; sig_next lets the owner see the value about to be latched.
import subckt_bist_pkg::*;

module bist_misr #(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS = MISR_W'(MISR_TAPS_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              serial_in,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_next
);
  always_comb begin
    sig_next = sig;
    if (clear)
      sig_next = '0;
    else if (enable)
      sig_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_TAPS : '0)
               ^ {{(MISR_W-1){1'b0}}, serial_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig <= '0;
    else        sig <= sig_next;
  end
endmodule

// File: rtl/subckt_bist_sequencer.sv
// BIST sequencer: resets the subcircuit, drives LFSR patterns, compacts its output
// in a MISR over a latency-aligned window and compares against a golden signature.
import subckt_bist_pkg::*;

module subckt_bist_sequencer #(
  parameter int                N_IN      = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS = MISR_W'(MISR_TAPS_DEF),
  parameter int                PATTERNS  = 256,
  parameter int                LATENCY   = 3
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              dut_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);
  localparam int            CW       = $clog2(PATTERNS + LATENCY + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(DUT_RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(PATTERNS - 1);
  localparam logic [CW-1:0] FL_LAST  = CW'(PATTERNS + LATENCY - 1);
  localparam logic [CW-1:0] CAP_START = CW'(LATENCY);

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [LFSR_W-1:0] lfsr, lfsr_d;
  logic [MISR_W-1:0] misr_next;
  logic              capture;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DUT_RST;
      DUT_RST: if (cnt == RST_LAST) state_next = RUN;
      RUN:     if (cnt == RUN_LAST) state_next = FLUSH;
      FLUSH:   if (cnt == FL_LAST)  state_next = DONE;
      DONE:    if (start) state_next = DUT_RST;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // lfsr_d is the pattern for the coming cycle, so dut_in can be registered in step
  always_comb begin
    lfsr_d = lfsr;
    if (state_next == DUT_RST)
      lfsr_d = LFSR_SEED;
    else if (state == RUN)
      lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  // cnt runs straight through RUN and FLUSH so the capture window is one compare
  assign capture = (state == RUN || state == FLUSH) && (cnt >= CAP_START);

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      dut_in    <= '0;
      dut_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_d;
      if (state_next != state && state_next != FLUSH)
        cnt <= '0;
      else if (state_next inside {DUT_RST, RUN, FLUSH})
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      dut_in    <= (state_next == RUN) ? lfsr_d[N_IN-1:0] : '0;
      dut_rst_n <= state_next inside {RUN, FLUSH, DONE};
      busy      <= state_next inside {DUT_RST, RUN, FLUSH};
      done      <= state_next == DONE;
      if (state_next == DONE)
        pass <= (state == DONE) ? pass : (misr_next == golden_sig);
      else
        pass <= 1'b0;
    end
  end

  bist_misr #(.MISR_W(MISR_W), .MISR_TAPS(MISR_TAPS)) u_misr (
    .clk       (I1470_clk),
    .rst_n     (I1477_rst),
    .clear     (state == DUT_RST),
    .enable    (capture),
    .serial_in (dut_out),
    .sig       (signature),
    .sig_next  (misr_next)
  );
endmodule

// File: tb/tb_subckt_bist_sequencer.sv
// Directed bench: three sequencers (PATTERNS 4, 1, 18; LATENCY 3) share control inputs.
module tb_subckt_bist_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  logic        dout_a, dout_b, dout_c;
  logic [15:0] gold_a, gold_b, gold_c;
  logic [2:0]  din_a, din_b, din_c;
  logic        drn_a, drn_b, drn_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;

  int tests = 0, fails = 0;

  subckt_bist_sequencer #(.PATTERNS(4), .LATENCY(3)) u_a (
    .I1470_clk(clk), .I1477_rst(rst), .start(start), .abort(abort), .golden_sig(gold_a),
    .dut_out(dout_a), .dut_in(din_a), .dut_rst_n(drn_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a));

  subckt_bist_sequencer #(.PATTERNS(1), .LATENCY(3)) u_b (
    .I1470_clk(clk), .I1477_rst(rst), .start(start), .abort(abort), .golden_sig(gold_b),
    .dut_out(dout_b), .dut_in(din_b), .dut_rst_n(drn_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b));

  subckt_bist_sequencer #(.PATTERNS(18), .LATENCY(3)) u_c (
    .I1470_clk(clk), .I1477_rst(rst), .start(start), .abort(abort), .golden_sig(gold_c),
    .dut_out(dout_c), .dut_in(din_c), .dut_rst_n(drn_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    dout_a = 1'b0; dout_b = 1'b1; dout_c = 1'b1;
    gold_a = 16'h0000; gold_b = 16'h0001; gold_c = 16'hCF9C;

    // reset state, before any clock edge
    #2;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_drn",  drn_a, 0);
    check("rst_sig",  sig_a, 0);
    check("rst_din",  din_a, 0);
    tick(2); rst = 1'b1; tick(1);
    check("idle_busy", busy_a, 0);

    // run 1: sequence timing, LFSR patterns, zero signature, single-capture, MISR wrap
    start = 1'b1; tick(1);
    check("r1_c1_busy", busy_a, 1);
    check("r1_c1_drn",  drn_a, 0);
    start = 1'b0; tick(2);
    check("r1_c3_din", din_a, 3'b001);
    check("r1_c3_drn", drn_a, 1);
    tick(1); check("r1_c4_din", din_a, 3'b000);
    tick(1); check("r1_c5_din", din_a, 3'b000);
    tick(1); check("r1_c6_din", din_a, 3'b100);
    tick(1);
    check("r1_c7_din",  din_a, 3'b000);
    check("r1_c7_busy", busy_a, 1);
    check("r1_c7_done_b", done_b, 1);
    check("r1_c7_sig_b",  sig_b, 16'h0001);
    tick(2);
    check("r1_c9_done", done_a, 0);
    tick(1);
    check("r1_c10_done", done_a, 1);
    check("r1_c10_busy", busy_a, 0);
    check("r1_c10_sig",  sig_a, 16'h0000);
    check("r1_c10_pass", pass_a, 1);
    check("r1_c10_drn",  drn_a, 1);
    check("r1_pass_b",   pass_b, 1);
    tick(13);
    check("r1_c23_done_c", done_c, 0);
    tick(1);
    check("r1_c24_done_c", done_c, 1);
    check("r1_c24_sig_c",  sig_c, 16'hCF9C);
    check("r1_c24_pass_c", pass_c, 1);
    check("r1_c24_done_a", done_a, 1);

    // run 2: golden mismatch, start held high mid-run, MISR clear on restart
    gold_a = 16'h0001;
    start = 1'b1; tick(1);
    check("r2_c1_busy", busy_a, 1);
    check("r2_c1_done", done_a, 0);
    check("r2_c1_pass", pass_a, 0);
    tick(1);
    check("r2_c2_sig_c", sig_c, 16'h0000);
    tick(1);
    check("r2_c3_din", din_a, 3'b001);
    tick(6);
    start = 1'b0; tick(1);
    check("r2_c10_done", done_a, 1);
    check("r2_c10_pass", pass_a, 0);
    check("r2_c10_sig",  sig_a, 16'h0000);
    tick(14);
    check("r2_c24_done_c", done_c, 1);
    check("r2_c24_sig_c",  sig_c, 16'hCF9C);

    // run 3: abort in RUN cycle 2, then a clean rerun
    dout_a = 1'b1; gold_a = 16'h000F;
    start = 1'b1; tick(1);
    start = 1'b0; tick(4);
    check("r3_c5_busy", busy_a, 1);
    abort = 1'b1; tick(1);
    check("ab_busy", busy_a, 0);
    check("ab_done", done_a, 0);
    check("ab_drn",  drn_a, 0);
    check("ab_pass", pass_a, 0);
    abort = 1'b0;
    start = 1'b1; tick(1);
    start = 1'b0; tick(9);
    check("r3_done", done_a, 1);
    check("r3_sig",  sig_a, 16'h000F);
    check("r3_pass", pass_a, 1);

    // run 4: async reset during FLUSH, then a normal run
    start = 1'b1; tick(1);
    start = 1'b0; tick(7);
    check("r4_c8_sig",  sig_a, 16'h0003);
    check("r4_c8_drn",  drn_a, 1);
    rst = 1'b0; #1;
    check("arst_drn",  drn_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_sig",  sig_a, 16'h0000);
    tick(1); rst = 1'b1; tick(1);
    start = 1'b1; tick(1);
    start = 1'b0; tick(9);
    check("r4_done", done_a, 1);
    check("r4_sig",  sig_a, 16'h000F);
    check("r4_pass", pass_a, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
